// File: rtl/lcd_nibble_writer_if.sv
// CPU-side byte handshake plus the 4-bit HD44780-style LCD bus driven by
// lcd_nibble_writer.
interface lcd_nibble_writer_if;
    // Handshake: a byte (iData, iRS) transfers on the rising clock edge where
    // iValid and oReady are both 1; iValid while oReady is 0 is dropped.
    logic [7:0] iData;
    logic       iRS;
    logic       iValid;
    logic       oReady;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_D;

    modport master (
        output iData, iRS, iValid,
        input  oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
    );

    modport slave (
        input  iData, iRS, iValid,
        output oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D
    );
endinterface

// File: rtl/lcd_nibble_writer.sv
// Serialises accepted bytes as two E-strobed nibbles and enforces the LCD
// execution delay. Define LCD_INIT_EN to add the power-on init sequence.
module lcd_nibble_writer #(
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_EN      = 12,
    parameter int unsigned T_NIB_GAP = 50,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_LONG    = 82000
`ifdef LCD_INIT_EN
    , parameter int unsigned T_POWERUP = 750000
`endif
) (
    input  logic                Clock,
    input  logic                Reset,
    lcd_nibble_writer_if.slave  bus,
    output logic [3:0]          o_state
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_H_SETUP = 4'd1;
    localparam logic [3:0] S_H_EN    = 4'd2;
    localparam logic [3:0] S_H_GAP   = 4'd3;
    localparam logic [3:0] S_L_SETUP = 4'd4;
    localparam logic [3:0] S_L_EN    = 4'd5;
    localparam logic [3:0] S_WAIT    = 4'd6;
`ifdef LCD_INIT_EN
    localparam logic [3:0] S_I_BOOT  = 4'd7;
    localparam logic [3:0] S_I_PWR   = 4'd8;
    localparam logic [3:0] S_I_SETUP = 4'd9;
    localparam logic [3:0] S_I_EN    = 4'd10;
    localparam logic [3:0] S_I_WAIT  = 4'd11;
    localparam logic [3:0] S_RESET   = S_I_BOOT;
    localparam logic [19:0] C_POWERUP = 20'(T_POWERUP - 1);
`else
    localparam logic [3:0] S_RESET   = S_IDLE;
`endif

    // Counter reload values: a phase lasting N cycles starts at N-1.
    localparam logic [19:0] C_SETUP = 20'(T_SETUP - 1);
    localparam logic [19:0] C_EN    = 20'(T_EN - 1);
    localparam logic [19:0] C_GAP   = 20'(T_NIB_GAP - 1);
    localparam logic [19:0] C_CMD   = 20'(T_CMD - 1);
    localparam logic [19:0] C_LONG  = 20'(T_LONG - 1);

    logic [3:0]  r_state;
    logic [19:0] r_cnt;
    logic [7:0]  r_data;
    logic        r_rs;
    logic        r_ready;
    logic        r_lcd_e;
    logic        r_lcd_rs;
    logic [3:0]  r_lcd_d;

    logic [3:0]  w_next_state;
    logic [19:0] w_next_cnt;
    logic        w_accept;
    logic        w_cnt_zero;
    logic        w_is_long;
    logic [7:0]  w_data_nx;
    logic        w_rs_nx;
    logic        w_next_e;
    logic        w_next_rs;
    logic [3:0]  w_next_d;
`ifdef LCD_INIT_EN
    logic [1:0]  r_step;
    logic [1:0]  w_next_step;
    logic [19:0] w_init_wait;
`endif

    always_comb begin
        w_accept     = bus.iValid & r_ready;
        w_cnt_zero   = (r_cnt == 20'd0);
        w_is_long    = ~r_rs & (r_data != 8'h00) & (r_data <= 8'h03);
        w_next_state = r_state;
        w_next_cnt   = w_cnt_zero ? 20'd0 : r_cnt - 20'd1;
`ifdef LCD_INIT_EN
        w_next_step  = r_step;
        case (r_step)
            2'd0:    w_init_wait = 20'd204999;
            2'd1:    w_init_wait = 20'd4999;
            default: w_init_wait = C_CMD;
        endcase
`endif
        case (r_state)
            S_IDLE:    if (w_accept)   begin w_next_state = S_H_SETUP; w_next_cnt = C_SETUP; end
            S_H_SETUP: if (w_cnt_zero) begin w_next_state = S_H_EN;    w_next_cnt = C_EN;    end
            S_H_EN:    if (w_cnt_zero) begin w_next_state = S_H_GAP;   w_next_cnt = C_GAP;   end
            S_H_GAP:   if (w_cnt_zero) begin w_next_state = S_L_SETUP; w_next_cnt = C_SETUP; end
            S_L_SETUP: if (w_cnt_zero) begin w_next_state = S_L_EN;    w_next_cnt = C_EN;    end
            S_L_EN: if (w_cnt_zero) begin
                w_next_state = S_WAIT;
                w_next_cnt   = w_is_long ? C_LONG : C_CMD;
            end
            S_WAIT:    if (w_cnt_zero) w_next_state = S_IDLE;
`ifdef LCD_INIT_EN
            S_I_BOOT:  begin w_next_state = S_I_PWR; w_next_cnt = C_POWERUP; end
            S_I_PWR:   if (w_cnt_zero) begin w_next_state = S_I_SETUP; w_next_cnt = C_SETUP; end
            S_I_SETUP: if (w_cnt_zero) begin w_next_state = S_I_EN;    w_next_cnt = C_EN;    end
            S_I_EN:    if (w_cnt_zero) begin w_next_state = S_I_WAIT;  w_next_cnt = w_init_wait; end
            S_I_WAIT: if (w_cnt_zero) begin
                if (r_step == 2'd3) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_I_SETUP;
                    w_next_cnt   = C_SETUP;
                    w_next_step  = r_step + 2'd1;
                end
            end
`endif
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they belong to; the accepted byte feeds through directly.
    always_comb begin
        w_data_nx = w_accept ? bus.iData : r_data;
        w_rs_nx   = w_accept ? bus.iRS : r_rs;
        w_next_e  = (w_next_state == S_H_EN) || (w_next_state == S_L_EN);
        w_next_rs = r_lcd_rs;
        w_next_d  = r_lcd_d;
        case (w_next_state)
            S_H_SETUP, S_H_EN, S_H_GAP: begin
                w_next_d  = w_data_nx[7:4];
                w_next_rs = w_rs_nx;
            end
            S_L_SETUP, S_L_EN, S_WAIT: begin
                w_next_d  = w_data_nx[3:0];
                w_next_rs = w_rs_nx;
            end
`ifdef LCD_INIT_EN
            S_I_BOOT, S_I_PWR: w_next_rs = 1'b0;
            S_I_SETUP, S_I_EN, S_I_WAIT: begin
                w_next_d  = (w_next_step == 2'd3) ? 4'h2 : 4'h3;
                w_next_rs = 1'b0;
                w_next_e  = (w_next_state == S_I_EN);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_RESET;
            r_cnt    <= 20'd0;
            r_data   <= 8'h00;
            r_rs     <= 1'b0;
            r_ready  <= 1'b0;
            r_lcd_e  <= 1'b0;
            r_lcd_rs <= 1'b0;
            r_lcd_d  <= 4'h0;
`ifdef LCD_INIT_EN
            r_step   <= 2'd0;
`endif
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            if (w_accept) begin
                r_data <= bus.iData;
                r_rs   <= bus.iRS;
            end
            r_ready  <= (w_next_state == S_IDLE);
            r_lcd_e  <= w_next_e;
            r_lcd_rs <= w_next_rs;
            r_lcd_d  <= w_next_d;
`ifdef LCD_INIT_EN
            r_step   <= w_next_step;
`endif
        end
    end

    assign bus.oReady  = r_ready;
    assign bus.oLCD_E  = r_lcd_e;
    assign bus.oLCD_RS = r_lcd_rs;
    assign bus.oLCD_RW = 1'b0;
    assign bus.oLCD_D  = r_lcd_d;
    assign o_state     = r_state;

endmodule
